// File: rtl/idma_inoc_rd_sched_if.sv
// idma_inoc_rd_sched_if
//   Bundles the command channel, the read-engine channel and the status
//   signals of the iNoC iDMA read-command scheduler.
//   slave  : scheduler side (idma_inoc_rd_sched)
//   master : command producer / read engine side
//   Signals:
//     cmd_valid/cmd_ready/cmd_word_addr/cmd_word_num : command push
//     abort                                          : single-cycle flush
//     ibuffer_rd_start/ibuffer_word_addr/ibuffer_word_num : chunk start
//     op_last_or_finish                              : abort pulse to engine
//     return_done                                    : engine chunk completion
//     cmd_done / busy                                : status
interface idma_inoc_rd_sched_if #(
    parameter int MEM_AW   = 15,
    parameter int WORD_NUM = 4
);
    localparam int WA = MEM_AW + $clog2(WORD_NUM);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [WA-1:0]   cmd_word_addr;
    logic [15:0]     cmd_word_num;
    logic            abort;
    logic            ibuffer_rd_start;
    logic [WA-1:0]   ibuffer_word_addr;
    logic [12:0]     ibuffer_word_num;
    logic            op_last_or_finish;
    logic            return_done;
    logic            cmd_done;
    logic            busy;

    modport slave (
        input  cmd_valid, cmd_word_addr, cmd_word_num, abort, return_done,
        output cmd_ready, ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num,
               op_last_or_finish, cmd_done, busy
    );

    modport master (
        output cmd_valid, cmd_word_addr, cmd_word_num, abort, return_done,
        input  cmd_ready, ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num,
               op_last_or_finish, cmd_done, busy
    );
endinterface

// File: rtl/idma_inoc_rd_sched.sv
// idma_inoc_rd_sched
//   Read-command scheduler in front of the iNoC iDMA ibuffer read engine.
//   Queues read commands (up to 65535 words) in a small FIFO and splits each
//   into engine chunks of at most CHUNK_WORDS words, issuing one start per
//   chunk and waiting for the engine's return_done before advancing.
//   abort flushes everything and pulses op_last_or_finish to the engine.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : idma_inoc_rd_sched_if.slave (command, engine, status)
module idma_inoc_rd_sched #(
    parameter int MEM_AW      = 15,
    parameter int WORD_NUM    = 4,
    parameter int CHUNK_WORDS = 4096,
    parameter int FIFO_DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    idma_inoc_rd_sched_if.slave  bus
);
    localparam int              WA       = MEM_AW + $clog2(WORD_NUM);
    localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [12:0]     CHUNK13  = 13'(CHUNK_WORDS);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t          r_state;
    state_t          w_next_state;

    // command FIFO
    logic [WA-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [15:0]     r_fifo_num  [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_next_count;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic [WA-1:0]   w_head_addr;
    logic [15:0]     w_head_num;

    // current command progress
    logic [WA-1:0]   r_cur_addr;
    logic [15:0]     r_remain;
    logic [12:0]     r_chunk;
    logic [WA-1:0]   w_step_addr;
    logic [15:0]     w_step_remain;

    logic            w_issue;
    logic            w_step;
    logic            w_done;
    logic [WA-1:0]   w_issue_addr;
    logic [15:0]     w_issue_remain;
    logic [12:0]     w_issue_chunk;

    // registered outputs
    logic            r_rd_start;
    logic [WA-1:0]   r_ib_addr;
    logic [12:0]     r_ib_num;
    logic            r_op_last;
    logic            r_cmd_done;
    logic            r_busy;

    assign w_ready     = (r_count != FULL_CNT) && !bus.abort;
    assign w_push      = bus.cmd_valid && w_ready;
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_num  = r_fifo_num[r_rd_ptr];

    // address wraps modulo 2^WA through the natural truncation of the sum
    assign w_step_addr   = r_cur_addr + WA'(r_chunk);
    assign w_step_remain = r_remain - {3'b000, r_chunk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_pop          = 1'b0;
        w_issue        = 1'b0;
        w_step         = 1'b0;
        w_done         = 1'b0;
        w_issue_addr   = w_head_addr;
        w_issue_remain = w_head_num;
        w_next_count   = r_count;

        if (r_state == ST_WAIT) begin
            w_issue_addr   = w_step_addr;
            w_issue_remain = w_step_remain;
        end

        if (bus.abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                        if (w_head_num == '0) begin
                            w_done = 1'b1;
                        end else begin
                            w_issue      = 1'b1;
                            w_next_state = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    w_next_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.return_done) begin
                        w_step = 1'b1;
                        if (w_step_remain == '0) begin
                            w_done       = 1'b1;
                            w_next_state = ST_IDLE;
                        end else begin
                            w_issue      = 1'b1;
                            w_next_state = ST_ISSUE;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end

        w_issue_chunk = (w_issue_remain > {3'b000, CHUNK13}) ? CHUNK13 : w_issue_remain[12:0];

        if (bus.abort) begin
            w_next_count = '0;
        end else if (w_push && !w_pop) begin
            w_next_count = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_next_count = r_count - CW'(1);
        end
    end

    // FIFO storage needs no reset: only entries below r_count are ever read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.cmd_word_addr;
            r_fifo_num[r_wr_ptr]  <= bus.cmd_word_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_next_count;
            if (bus.abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // Chunk address/count are loaded one cycle ahead of ISSUE so they are
    // already valid while ibuffer_rd_start is high, then held until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr <= '0;
            r_remain   <= '0;
            r_chunk    <= '0;
            r_rd_start <= 1'b0;
            r_ib_addr  <= '0;
            r_ib_num   <= '0;
            r_op_last  <= 1'b0;
            r_cmd_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rd_start <= w_issue;
            r_cmd_done <= w_done;
            r_op_last  <= bus.abort;
            r_busy     <= (w_next_state != ST_IDLE) || (w_next_count != '0);

            if (bus.abort) begin
                r_remain <= '0;
                r_chunk  <= '0;
            end else if (w_pop) begin
                r_cur_addr <= w_head_addr;
                r_remain   <= w_head_num;
            end else if (w_step) begin
                r_cur_addr <= w_step_addr;
                r_remain   <= w_step_remain;
            end

            if (w_issue) begin
                r_ib_addr <= w_issue_addr;
                r_ib_num  <= w_issue_chunk;
                r_chunk   <= w_issue_chunk;
            end
        end
    end

    assign bus.cmd_ready         = w_ready;
    assign bus.ibuffer_rd_start  = r_rd_start;
    assign bus.ibuffer_word_addr = r_ib_addr;
    assign bus.ibuffer_word_num  = r_ib_num;
    assign bus.op_last_or_finish = r_op_last;
    assign bus.cmd_done          = r_cmd_done;
    assign bus.busy              = r_busy;
endmodule
